// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU evaluates) -> RESP (hold result).
module alu_arbiter #(
  parameter int WORD_SIZE    = 8,
  parameter int ALU_CON_SIZE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [2*ALU_CON_SIZE-1:0] req_op,
  input  logic [2*WORD_SIZE-1:0]    req_a,
  input  logic [2*WORD_SIZE-1:0]    req_b,
  output logic [1:0]                resp_valid,
  input  logic [1:0]                resp_ready,
  output logic [WORD_SIZE-1:0]      resp_data,
  output logic                      resp_ovf,
  output logic                      resp_err,
  output logic [ALU_CON_SIZE-1:0]   alu_con,
  output logic [WORD_SIZE-1:0]      alu_in_1,
  output logic [WORD_SIZE-1:0]      alu_in_2,
  input  logic [WORD_SIZE-1:0]      alu_out
);

  localparam logic [ALU_CON_SIZE-1:0] OP_AND = ALU_CON_SIZE'(4'b0000);
  localparam logic [ALU_CON_SIZE-1:0] OP_OR  = ALU_CON_SIZE'(4'b0001);
  localparam logic [ALU_CON_SIZE-1:0] OP_ADD = ALU_CON_SIZE'(4'b0010);
  localparam logic [ALU_CON_SIZE-1:0] OP_SUB = ALU_CON_SIZE'(4'b0110);
  localparam logic [ALU_CON_SIZE-1:0] OP_NOR = ALU_CON_SIZE'(4'b1111);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t                  r_state;
  logic                    r_last_grant;
  logic                    r_grant;
  logic                    r_legal;
  logic [ALU_CON_SIZE-1:0] r_op;
  logic [WORD_SIZE-1:0]    r_a;
  logic [WORD_SIZE-1:0]    r_b;

  logic                    w_grant;
  logic                    w_take;
  logic                    w_sel_legal;
  logic                    w_ovf;
  logic [ALU_CON_SIZE-1:0] w_sel_op;
  logic [WORD_SIZE-1:0]    w_sel_a;
  logic [WORD_SIZE-1:0]    w_sel_b;

  function automatic logic is_legal(input logic [ALU_CON_SIZE-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_NOR);
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_grant = req_valid[1];
    if (req_valid == 2'b11) w_grant = ~r_last_grant;
  end

  assign w_sel_op    = w_grant ? req_op[2*ALU_CON_SIZE-1:ALU_CON_SIZE] : req_op[ALU_CON_SIZE-1:0];
  assign w_sel_a     = w_grant ? req_a[2*WORD_SIZE-1:WORD_SIZE] : req_a[WORD_SIZE-1:0];
  assign w_sel_b     = w_grant ? req_b[2*WORD_SIZE-1:WORD_SIZE] : req_b[WORD_SIZE-1:0];
  assign w_sel_legal = is_legal(w_sel_op);

  // Ready is gated by rst so the reset state shows no accept even with valid held high.
  assign w_take    = (r_state == S_IDLE) && (req_valid != 2'b00) && !rst;
  assign req_ready = w_take ? (2'b01 << w_grant) : 2'b00;

  // Signed overflow from the operand signs and the sign of the ALU result.
  always_comb begin
    w_ovf = 1'b0;
    if (r_op == OP_ADD)
      w_ovf = (r_a[WORD_SIZE-1] == r_b[WORD_SIZE-1]) &&
              (alu_out[WORD_SIZE-1] != r_a[WORD_SIZE-1]);
    else if (r_op == OP_SUB)
      w_ovf = (r_a[WORD_SIZE-1] != r_b[WORD_SIZE-1]) &&
              (alu_out[WORD_SIZE-1] != r_a[WORD_SIZE-1]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_legal      <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      resp_valid   <= 2'b00;
      resp_data    <= '0;
      resp_ovf     <= 1'b0;
      resp_err     <= 1'b0;
      alu_con      <= '0;
      alu_in_1     <= '0;
      alu_in_2     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_grant <= w_grant;
            r_legal <= w_sel_legal;
            r_op    <= w_sel_op;
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            // ALU inputs load here so they are stable for the whole EXEC cycle.
            if (w_sel_legal) begin
              alu_con  <= w_sel_op;
              alu_in_1 <= w_sel_a;
              alu_in_2 <= w_sel_b;
            end
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          resp_valid <= 2'b01 << r_grant;
          if (r_legal) begin
            resp_data <= alu_out;
            resp_ovf  <= w_ovf;
            resp_err  <= 1'b0;
          end else begin
            resp_data <= '0;
            resp_ovf  <= 1'b0;
            resp_err  <= 1'b1;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready[r_grant]) begin
            resp_valid   <= 2'b00;
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, hand-written corner sequences
// and randomized transactions scored against an arithmetic reference model.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [7:0]  resp_data;
  logic        resp_ovf;
  logic        resp_err;
  logic [3:0]  alu_con;
  logic [7:0]  alu_in_1;
  logic [7:0]  alu_in_2;
  logic [7:0]  alu_out;

  int n_checks = 0;
  int n_errors = 0;
  int m_last   = 1;

  alu_arbiter #(.WORD_SIZE(8), .ALU_CON_SIZE(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_ovf(resp_ovf), .resp_err(resp_err),
    .alu_con(alu_con), .alu_in_1(alu_in_1), .alu_in_2(alu_in_2),
    .alu_out(alu_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Lab ALU stand-in driven by the DUT's ALU control outputs.
  always_comb begin
    case (alu_con)
      4'b0010: alu_out = alu_in_1 + alu_in_2;
      4'b0110: alu_out = alu_in_1 - alu_in_2;
      4'b0000: alu_out = alu_in_1 & alu_in_2;
      4'b0001: alu_out = alu_in_1 | alu_in_2;
      4'b1111: alu_out = ~(alu_in_1 | alu_in_2);
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on signed operands, overflow = result out of 8-bit range.
  function automatic void ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] d, output logic o, output logic e);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    o  = 1'b0;
    e  = 1'b0;
    case (op)
      4'b0010: begin r = sa + sb; o = (r > 127) || (r < -128); end
      4'b0110: begin r = sa - sb; o = (r > 127) || (r < -128); end
      4'b0000: r = int'(a & b);
      4'b0001: r = int'(a | b);
      4'b1111: r = int'(~(a | b));
      default: e = 1'b1;
    endcase
    d = r[7:0];
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_op     = 8'h00;
    req_a      = 16'h0000;
    req_b      = 16'h0000;
    resp_ready = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_last = 1;
  endtask

  // One full transaction; called with the DUT in IDLE, away from a clock edge.
  task automatic run_txn(input logic [1:0] vld, input logic [7:0] ops, input logic [15:0] as,
                         input logic [15:0] bs, input int hold, input int ew,
                         input logic [7:0] ed, input logic eo, input logic ee);
    logic [3:0] op, prev_con;
    logic [7:0] a, b, prev_i1, prev_i2;
    logic [1:0] ev;
    op = (ew == 1) ? ops[7:4] : ops[3:0];
    a  = (ew == 1) ? as[15:8] : as[7:0];
    b  = (ew == 1) ? bs[15:8] : bs[7:0];
    ev = (ew == 1) ? 2'b10 : 2'b01;
    req_valid  = vld;
    req_op     = ops;
    req_a      = as;
    req_b      = bs;
    resp_ready = 2'b00;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'(ev));
    prev_con = alu_con;
    prev_i1  = alu_in_1;
    prev_i2  = alu_in_2;
    @(posedge clk); #1;
    req_valid = 2'b00;
    #1;
    check("exec_req_ready", 32'(req_ready), 32'd0);
    check("exec_resp_valid", 32'(resp_valid), 32'd0);
    check("exec_alu_con", 32'(alu_con), ee ? 32'(prev_con) : 32'(op));
    check("exec_alu_in_1", 32'(alu_in_1), ee ? 32'(prev_i1) : 32'(a));
    check("exec_alu_in_2", 32'(alu_in_2), ee ? 32'(prev_i2) : 32'(b));
    @(posedge clk); #1;
    check("resp_valid", 32'(resp_valid), 32'(ev));
    check("resp_data", 32'(resp_data), 32'(ed));
    check("resp_ovf", 32'(resp_ovf), 32'(eo));
    check("resp_err", 32'(resp_err), 32'(ee));
    for (int i = 0; i < hold; i++) begin
      resp_ready = ~ev;
      @(posedge clk); #1;
      check("hold_resp_valid", 32'(resp_valid), 32'(ev));
      check("hold_resp_data", 32'(resp_data), 32'(ed));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = ev;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    check("done_resp_valid", 32'(resp_valid), 32'd0);
    m_last = ew;
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [7:0]  ops;
    logic [15:0] as;
    logic [15:0] bs;
    int          hold;
    int          ew;
    logic [7:0]  ed;
    logic        eo;
    logic        ee;
  } vec_t;

  vec_t       vecs [13];
  logic [3:0] legal_ops [5];

  initial begin
    int         exp_g, n_grants;
    logic [1:0] vld;
    logic [3:0] op0, op1;
    logic [7:0] ops, rd;
    logic [15:0] ras, rbs;
    logic       ro, re;
    int         w;

    legal_ops = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1111};
    vecs[0]  = '{2'b01, 8'h02, 16'h0064, 16'h0032, 0, 0, 8'h96, 1'b1, 1'b0};
    vecs[1]  = '{2'b10, 8'h60, 16'h8000, 16'h0100, 0, 1, 8'h7F, 1'b1, 1'b0};
    vecs[2]  = '{2'b10, 8'hF0, 16'h0F00, 16'hF000, 0, 1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 8'h01, 16'h0012, 16'h0021, 0, 0, 8'h33, 1'b0, 1'b0};
    vecs[4]  = '{2'b01, 8'h03, 16'h0055, 16'h00AA, 1, 0, 8'h00, 1'b0, 1'b1};
    vecs[5]  = '{2'b11, 8'h00, 16'hF0F0, 16'h3C3C, 0, 1, 8'h30, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 8'h00, 16'hF0F0, 16'h3C3C, 0, 0, 8'h30, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 8'h00, 16'hF0F0, 16'h3C3C, 2, 1, 8'h30, 1'b0, 1'b0};
    vecs[8]  = '{2'b01, 8'h02, 16'h007F, 16'h0001, 3, 0, 8'h80, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 8'h20, 16'hFF00, 16'hFF00, 0, 1, 8'hFE, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 8'h06, 16'h007F, 16'h00FF, 0, 0, 8'h80, 1'b1, 1'b0};
    vecs[11] = '{2'b10, 8'h60, 16'h0500, 16'h0300, 0, 1, 8'h02, 1'b0, 1'b0};
    vecs[12] = '{2'b11, 8'h12, 16'h1180, 16'h2280, 0, 0, 8'h00, 1'b1, 1'b0};

    // Reset state.
    rst        = 1'b1;
    req_valid  = 2'b01;
    req_op     = 8'h00;
    req_a      = 16'h0000;
    req_b      = 16'h0000;
    resp_ready = 2'b00;
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_flags", 32'({resp_ovf, resp_err}), 32'd0);
    check("rst_alu", 32'({alu_con, alu_in_1, alu_in_2}), 32'd0);

    // Both requesters held valid from reset: grants alternate starting with req0.
    req_valid  = 2'b11;
    req_a      = 16'hF0F0;
    req_b      = 16'h3C3C;
    resp_ready = 2'b11;
    @(negedge clk);
    rst      = 1'b0;
    exp_g    = 0;
    n_grants = 0;
    #1;
    for (int c = 0; c < 30; c++) begin
      check("rr_not_both", 32'(req_ready == 2'b11), 32'd0);
      if (req_ready != 2'b00) begin
        check("rr_alternate", 32'(req_ready), (exp_g == 1) ? 32'd2 : 32'd1);
        exp_g = 1 - exp_g;
        n_grants++;
      end
      if (resp_valid != 2'b00) check("rr_resp_data", 32'(resp_data), 32'h30);
      @(negedge clk); #1;
    end
    check("rr_grant_count", 32'(n_grants >= 4), 32'd1);

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 13; i++)
      run_txn(vecs[i].vld, vecs[i].ops, vecs[i].as, vecs[i].bs, vecs[i].hold,
              vecs[i].ew, vecs[i].ed, vecs[i].eo, vecs[i].ee);

    // Response back-pressure while req1 waits; req1 wins right after the release.
    req_valid = 2'b01;
    req_op    = 8'h02;
    req_a     = 16'hF003;
    req_b     = 16'h3C04;
    #1;
    check("bp_grant0", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid  = 2'b10;
    req_op     = 8'h00;
    resp_ready = 2'b10;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_data", 32'(resp_data), 32'h07);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 2'b01;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    check("bp_grant1", 32'(req_ready), 32'd2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    check("bp_resp1_valid", 32'(resp_valid), 32'd2);
    check("bp_resp1_data", 32'(resp_data), 32'h30);
    resp_ready = 2'b10;
    @(posedge clk); #1;
    resp_ready = 2'b00;
    m_last = 1;

    // Randomized transactions against the reference model.
    for (int n = 0; n < 150; n++) begin
      vld = 2'($urandom_range(1, 3));
      op0 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 4)];
      op1 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 4)];
      ops = {op1, op0};
      ras = 16'($urandom);
      rbs = 16'($urandom);
      w   = (vld == 2'b11) ? (1 - m_last) : (vld[1] ? 1 : 0);
      if (w == 1) ref_alu(op1, ras[15:8], rbs[15:8], rd, ro, re);
      else        ref_alu(op0, ras[7:0], rbs[7:0], rd, ro, re);
      run_txn(vld, ops, ras, rbs, $urandom_range(0, 2), w, rd, ro, re);
    end

    // Reset pulsed during EXEC aborts the operation; req0 wins first afterwards.
    req_valid = 2'b01;
    req_op    = 8'h02;
    req_a     = 16'h0011;
    req_b     = 16'h0022;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_data", 32'(resp_data), 32'd0);
    check("abort_flags", 32'({resp_ovf, resp_err}), 32'd0);
    check("abort_alu", 32'({alu_con, alu_in_1, alu_in_2}), 32'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    req_valid = 2'b11;
    req_op    = 8'h00;
    #1;
    check("abort_first_grant", 32'(req_ready), 32'd1);
    req_valid = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU between two requesters, each using a valid/ready request and a valid/ready response.
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU control and operand inputs from registers, captures the ALU result, and flags signed overflow for ADD/SUB.
- Sits between the lab ALU and its clients (sequencer, testbench drivers).

Parameters:
WORD_SIZE, 8, operand/result width
ALU_CON_SIZE, 4, ALU control code width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  2  per-requester request valid (bit n = requester n)
req_ready  output  2  per-requester request accept (one-hot or zero)
req_op  input  2*ALU_CON_SIZE  op codes; [3:0] = req0, [7:4] = req1
req_a  input  2*WORD_SIZE  signed operand A; [7:0] = req0, [15:8] = req1
req_b  input  2*WORD_SIZE  signed operand B, same packing
resp_valid  output  2  response valid, at most one bit set
resp_ready  input  2  per-requester response accept
resp_data  output  WORD_SIZE  result for the requester whose resp_valid is set
resp_ovf  output  1  signed overflow (ADD/SUB only)
resp_err  output  1  illegal op code
alu_con  output  ALU_CON_SIZE  ALU control
alu_in_1  output  WORD_SIZE  ALU operand 1
alu_in_2  output  WORD_SIZE  ALU operand 2
alu_out  input  WORD_SIZE  ALU result (combinational from alu_con/alu_in_*)

Behaviour:
- Legal op codes: ADD=4'b0010, SUB=4'b0110, AND=4'b0000, OR=4'b0001, NOR=4'b1111. All other codes are illegal.
- Reset (async, rst=1): state IDLE; req_ready=0; resp_valid=0; resp_data=0; resp_ovf=0; resp_err=0; alu_con=0; alu_in_1=0; alu_in_2=0; last_grant=1, so req0 wins first.

FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Grant g is the requester with valid set. If both are valid, grant the one not equal to last_grant.
  - req_ready[g] is asserted combinationally in IDLE only. The handshake completes in that cycle.
  - On handshake: latch op/a/b and g; go to EXEC.
  - If no request is valid, stay in IDLE with req_ready=0.
- EXEC (one cycle):
  - For a legal op, alu_con/alu_in_1/alu_in_2 show the latched values for this whole cycle.
  - At the clock edge ending EXEC: resp_data<=alu_out, compute resp_ovf, resp_err<=0, resp_valid[g]<=1; go to RESP.
  - For an illegal op, alu_con/alu_in_* are not updated (they hold previous values). resp_data<=0, resp_ovf<=0, resp_err<=1, resp_valid[g]<=1.
- RESP:
  - Hold resp_valid/resp_data/resp_ovf/resp_err stable until resp_ready[g]=1.
  - On that edge: clear resp_valid, last_grant<=g, go to IDLE.
  - resp_ready on the non-granted bit is ignored.
- Latency: handshake at edge T -> resp_valid high after edge T+1, i.e. visible in cycle T+2. Minimum of 3 cycles per operation.
- alu_con/alu_in_* hold their last values outside EXEC.
- Overflow (signed, WORD_SIZE bits):
  - ADD: sign(a)==sign(b) and sign(result)!=sign(a).
  - SUB: sign(a)!=sign(b) and sign(result)!=sign(a).
  - AND/OR/NOR: 0.
- Results wrap modulo 2^WORD_SIZE.
- No new request is accepted in EXEC or RESP; req_ready is 0 in both.
- A requester may drop req_valid before it is granted. Nothing is captured and there is no error.
- Reset in any state aborts the transaction immediately; no response is ever produced for it.

Test Plan:
1. req0 ADD a=100, b=50, resp_ready=1 -> alu_con=0010 in EXEC; resp_valid=2'b01 two cycles after handshake; resp_data=-106 (8'h96); resp_ovf=1; resp_err=0.
2. Both req_valid held from reset, all ops AND 8'hF0&8'h3C -> grants alternate req0, req1, req0, req1; resp_data=8'h30 each time; req_ready never 2'b11.
3. req1 SUB a=-128, b=1 -> resp_data=127, resp_ovf=1. Then req1 NOR a=8'h0F, b=8'hF0 -> resp_data=8'h00, resp_ovf=0.
4. req0 op 4'b0011 after a prior OR operation -> resp_err=1, resp_data=0, alu_con keeps 0001 throughout.
5. resp_ready=0 for 5 cycles in RESP with req1 valid -> resp_valid/resp_data stable and req_ready=0 throughout; req1 granted the cycle after resp_ready[0]=1.
6. rst pulsed during EXEC -> all outputs return to reset values immediately; no resp_valid; first post-reset grant goes to req0.
